// File: rtl/disp_cmd_fifo_writer.sv
`default_nettype none
// ============================================================================
//  Module      : disp_cmd_fifo_writer
//  Description : Host-side producer for the display command FIFO. Buffers
//                command bytes from a valid/ready stream and writes them into
//                an external async FIFO with a timed active-low write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_cmd_fifo_writer #(
  parameter int BUF_AW      = 2,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 6,
  parameter int RECOVER_CYC = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [7:0]        fifo_d,
  output logic              nwr,
  input  logic              nff_in,
  output logic [BUF_AW:0]   buf_level,
  output logic              busy
);

  localparam int c_DEPTH   = 2 ** BUF_AW;
  localparam int c_MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int c_MAX_CYC = (c_MAX_SP > RECOVER_CYC) ? c_MAX_SP : RECOVER_CYC;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;

  localparam logic [BUF_AW:0]    c_FULL_LVL   = (BUF_AW + 1)'(c_DEPTH);
  localparam logic [BUF_AW:0]    c_LVL_ONE    = (BUF_AW + 1)'(1);
  localparam logic [BUF_AW-1:0]  c_PTR_ONE    = BUF_AW'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_SETUP_LD   = c_CNT_W'(SETUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_PULSE_LD   = c_CNT_W'(PULSE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_RECOVER_LD = c_CNT_W'(RECOVER_CYC - 1);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_SETUP   = 2'd1,
    W_PULSE   = 2'd2,
    W_RECOVER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic                r_nwr;
  logic                w_nwr_nxt;
  logic [7:0]          r_fifo_d;
  logic [7:0]          w_fifo_d_nxt;

  logic [7:0]          r_mem [c_DEPTH];
  logic [BUF_AW-1:0]   r_head;
  logic [BUF_AW-1:0]   r_tail;
  logic [BUF_AW:0]     r_level;

  logic                r_nff_s1;
  logic                r_nff_s2;

  logic                w_push;
  logic                w_pop;

  assign cmd_ready = (r_level != c_FULL_LVL);
  assign w_push    = cmd_valid & cmd_ready;
  assign fifo_d    = r_fifo_d;
  assign nwr       = r_nwr;
  assign buf_level = r_level;
  assign busy      = (r_state != W_IDLE);

  // Two-flop synchronizer for the asynchronous full flag; reset reads as full.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_nff_s1 <= 1'b0;
      r_nff_s2 <= 1'b0;
    end else begin
      r_nff_s1 <= nff_in;
      r_nff_s2 <= r_nff_s1;
    end
  end

  // Buffer storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (nrst && w_push) begin
      r_mem[r_tail] <= cmd_data;
    end
  end

  // Circular buffer pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Write-cycle state register plus registered strobe and data outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= W_IDLE;
      r_cnt    <= '0;
      r_nwr    <= 1'b1;
      r_fifo_d <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_nwr    <= w_nwr_nxt;
      r_fifo_d <= w_fifo_d_nxt;
    end
  end

  // Next-state logic: launch only from idle when data is held and not full.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_nwr_nxt    = r_nwr;
    w_fifo_d_nxt = r_fifo_d;
    w_pop        = 1'b0;
    case (r_state)
      W_IDLE: begin
        w_nwr_nxt = 1'b1;
        if ((r_level != '0) && r_nff_s2) begin
          w_fifo_d_nxt = r_mem[r_head];
          w_pop        = 1'b1;
          w_cnt_nxt    = c_SETUP_LD;
          w_state_nxt  = W_SETUP;
        end
      end
      W_SETUP: begin
        w_nwr_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_nwr_nxt   = 1'b0;
          w_cnt_nxt   = c_PULSE_LD;
          w_state_nxt = W_PULSE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      W_PULSE: begin
        w_nwr_nxt = 1'b0;
        if (r_cnt == '0) begin
          w_nwr_nxt   = 1'b1;
          w_cnt_nxt   = c_RECOVER_LD;
          w_state_nxt = W_RECOVER;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      W_RECOVER: begin
        w_nwr_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = W_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      default: begin
        w_nwr_nxt   = 1'b1;
        w_state_nxt = W_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_cmd_fifo_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_cmd_fifo_writer
//  Description : Directed self-checking bench for disp_cmd_fifo_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_cmd_fifo_writer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] fifo_d;
  logic       nwr;
  logic       nff_in = 1'b1;
  logic [2:0] buf_level;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         fall_q[$];
  int         width_q[$];
  logic [7:0] rx_q[$];
  int         launch_q[$];
  int         busy_len_q[$];
  logic       prev_nwr;
  logic       prev_busy;
  int         low_start;
  int         busy_start;

  disp_cmd_fifo_writer #(
    .BUF_AW(2), .SETUP_CYC(2), .PULSE_CYC(6), .RECOVER_CYC(4)
  ) dut (
    .clk(clk), .nrst(nrst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .fifo_d(fifo_d), .nwr(nwr), .nff_in(nff_in),
    .buf_level(buf_level), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO-side observer: strobe edges, pulse widths, latched bytes, busy spans.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_nwr === 1'b1 && nwr === 1'b0) begin
      fall_q.push_back(cyc);
      low_start = cyc;
    end
    if (prev_nwr === 1'b0 && nwr === 1'b1 && nrst === 1'b1) begin
      width_q.push_back(cyc - low_start);
      rx_q.push_back(fifo_d);
    end
    if (prev_busy === 1'b0 && busy === 1'b1) begin
      launch_q.push_back(cyc);
      busy_start = cyc;
    end
    if (prev_busy === 1'b1 && busy === 1'b0 && nrst === 1'b1) begin
      busy_len_q.push_back(cyc - busy_start);
    end
    prev_nwr  = nwr;
    prev_busy = busy;
  end

  task automatic clear_logs();
    fall_q.delete();
    width_q.delete();
    rx_q.delete();
    launch_q.delete();
    busy_len_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic push_byte(input logic [7:0] b, inout int stalls);
    int t;
    cmd_data  = b;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      n_checks++;
      if (buf_level !== 3'd4) begin
        n_fail++;
        $display("FAIL ready_low_level: buf_level=%0d required 4", buf_level);
      end
      stalls++;
      t++;
      @(negedge clk);
    end
    if (t >= 100) begin
      n_fail++;
      $display("FAIL push_timeout: byte %02h not accepted, required accept", b);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (rx_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_rx_timeout: got %0d writes required %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    nrst      = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 8'h55;
    repeat (3) @(negedge clk);
    n_checks++;
    if (nwr !== 1'b1) begin n_fail++; $display("FAIL rst_nwr: got %b required 1", nwr); end
    n_checks++;
    if (fifo_d !== 8'h00) begin n_fail++; $display("FAIL rst_fifo_d: got %02h required 00", fifo_d); end
    n_checks++;
    if (buf_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d required 0", buf_level); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    cmd_valid = 1'b0;
    nrst      = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", cmd_ready); end
    n_checks++;
    if (buf_level !== 3'd0) begin n_fail++; $display("FAIL rst_no_push: level %0d required 0", buf_level); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_write();
    int st;
    st = 0;
    clear_logs();
    push_byte(8'hA5, st);
    cmd_valid = 1'b0;
    n_checks++;
    if (buf_level !== 3'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pushed: level=%0d busy=%b required 1/0", buf_level, busy);
    end
    @(negedge clk);
    n_checks++;
    if (fifo_d !== 8'hA5 || busy !== 1'b1 || nwr !== 1'b1 || buf_level !== 3'd0) begin
      n_fail++;
      $display("FAIL single_launch: fifo_d=%02h busy=%b nwr=%b level=%0d required A5/1/1/0",
               fifo_d, busy, nwr, buf_level);
    end
    wait_idle("single");
    n_checks++;
    if (fall_q.size() != 1 || launch_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_counts: falls=%0d launches=%0d required 1/1", fall_q.size(), launch_q.size());
    end
    n_checks++;
    if (fall_q[0] - launch_q[0] != 2) begin
      n_fail++;
      $display("FAIL single_setup: got %0d cycles required 2", fall_q[0] - launch_q[0]);
    end
    n_checks++;
    if (width_q[0] != 6) begin n_fail++; $display("FAIL single_pulse: got %0d required 6", width_q[0]); end
    n_checks++;
    if (busy_len_q[0] != 12) begin n_fail++; $display("FAIL single_busy: got %0d required 12", busy_len_q[0]); end
    n_checks++;
    if (rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %02h required A5", rx_q[0]); end
  endtask

  task automatic test_back_to_back();
    int st;
    st = 0;
    clear_logs();
    for (int i = 1; i <= 6; i++) push_byte(8'(i), st);
    cmd_valid = 1'b0;
    n_checks++;
    if (st == 0) begin n_fail++; $display("FAIL burst_ready_drop: stalls=%0d required >0", st); end
    wait_rx(6, 150, "burst");
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (rx_q[k] !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL burst_data[%0d]: got %02h required %02h", k, rx_q[k], 8'(k + 1));
      end
    end
    for (int k = 1; k < 6; k++) begin
      n_checks++;
      if (fall_q[k] - fall_q[k-1] != 13) begin
        n_fail++;
        $display("FAIL burst_period[%0d]: got %0d required 13", k, fall_q[k] - fall_q[k-1]);
      end
    end
    wait_idle("burst");
  endtask

  task automatic test_full_stall();
    int st;
    int c;
    st = 0;
    clear_logs();
    nff_in = 1'b0;
    repeat (3) @(negedge clk);
    push_byte(8'h11, st);
    push_byte(8'h22, st);
    push_byte(8'h33, st);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (fall_q.size() != 0 || busy !== 1'b0 || nwr !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_write: falls=%0d busy=%b nwr=%b required 0/0/1", fall_q.size(), busy, nwr);
    end
    n_checks++;
    if (buf_level !== 3'd3) begin n_fail++; $display("FAIL stall_level: got %0d required 3", buf_level); end
    nff_in = 1'b1;
    c = cyc;
    wait_rx(3, 100, "stall");
    n_checks++;
    if (fall_q.size() != 3) begin n_fail++; $display("FAIL stall_writes: got %0d required 3", fall_q.size()); end
    n_checks++;
    if (fall_q[0] - c > 5) begin
      n_fail++;
      $display("FAIL stall_resume: first fall after %0d cycles required <=5", fall_q[0] - c);
    end
    n_checks++;
    if (rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_q[2] !== 8'h33) begin
      n_fail++;
      $display("FAIL stall_data: got %02h %02h %02h required 11 22 33", rx_q[0], rx_q[1], rx_q[2]);
    end
    wait_idle("stall");
  endtask

  task automatic test_full_mid_cycle();
    int st;
    int t;
    st = 0;
    clear_logs();
    push_byte(8'h3C, st);
    push_byte(8'hC3, st);
    cmd_valid = 1'b0;
    t = 0;
    while (nwr !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    nff_in = 1'b0;
    wait_rx(1, 40, "midfull");
    n_checks++;
    if (width_q[0] != 6 || rx_q[0] !== 8'h3C) begin
      n_fail++;
      $display("FAIL midfull_complete: width=%0d data=%02h required 6/3C", width_q[0], rx_q[0]);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (fall_q.size() != 1 || busy !== 1'b0 || buf_level !== 3'd1) begin
      n_fail++;
      $display("FAIL midfull_hold: falls=%0d busy=%b level=%0d required 1/0/1",
               fall_q.size(), busy, buf_level);
    end
    nff_in = 1'b1;
    wait_rx(2, 40, "midfull");
    n_checks++;
    if (rx_q[1] !== 8'hC3) begin n_fail++; $display("FAIL midfull_resume: got %02h required C3", rx_q[1]); end
    wait_idle("midfull");
  endtask

  task automatic test_reset_mid_pulse();
    int st;
    int t;
    st = 0;
    clear_logs();
    push_byte(8'h77, st);
    push_byte(8'h88, st);
    cmd_valid = 1'b0;
    t = 0;
    while (nwr !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (nwr !== 1'b1 || buf_level !== 3'd0 || busy !== 1'b0 || fifo_d !== 8'h00) begin
      n_fail++;
      $display("FAIL rstpulse_release: nwr=%b level=%0d busy=%b fifo_d=%02h required 1/0/0/00",
               nwr, buf_level, busy, fifo_d);
    end
    nrst = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (fall_q.size() != 1 || rx_q.size() != 0 || nwr !== 1'b1 || busy !== 1'b0 || buf_level !== 3'd0) begin
      n_fail++;
      $display("FAIL rstpulse_idle: falls=%0d writes=%0d nwr=%b busy=%b level=%0d required 1/0/1/0/0",
               fall_q.size(), rx_q.size(), nwr, busy, buf_level);
    end
  endtask

  // Sequence of directed scenarios followed by the summary.
  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_full_stall();
    test_full_mid_cycle();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
